bus_arbiter_rr: RTL and testbench
=================================

// Module: bus_arbiter_rr
//
// PURPOSE
//   Round-robin arbiter for the shared single-wire data_bus built from tristate
//   drivers. Sits directly upstream of the tristate stage: each grant bit drives
//   one tristate enable, replacing the raw select pin. Guarantees at most one
//   driver is enabled and inserts break-before-make dead time before every new
//   grant, so two drivers never fight on the bus.
//
// PARAMETERS
//   N_REQ     2   number of requesters/tristate drivers (legal 2..8)
//   DEAD_CYC  1   idle cycles with no driver enabled before any grant (>=1)
//   MAX_HOLD  16  max consecutive grant cycles per owner; 0 = unlimited
//
// PORTS
//   CLK           in   1      system clock, all state on rising edge
//   rst_n         in   1      asynchronous active-low reset
//   req           in   N_REQ  request, bit i = requester i wants the bus (level)
//   grant         out  N_REQ  one-hot-or-zero tristate enables, registered
//   owner         out  OW     index of current owner; OW = clog2(N_REQ)
//   bus_busy      out  1      1 while any grant bit is high
//   timeout_pulse out  1      1-cycle pulse when MAX_HOLD forces a release
//
// BEHAVIOUR
//   - Reset (async, rst_n=0): grant=0, owner=0, bus_busy=0, timeout_pulse=0,
//     state=IDLE, rr pointer=0, counters=0. Takes effect immediately, also
//     mid-grant; grant must drop without waiting for CLK.
//   - States: IDLE, DEAD, OWN. All outputs registered.
//   - IDLE: if req!=0 at an edge, pick winner w = first set bit scanning from
//     rr pointer upward with wrap; latch w; go DEAD, dead counter=DEAD_CYC-1.
//     req==0: stay IDLE.
//   - DEAD: grant=0. Decrement each edge; at edge with counter==0: if req[w]=1
//     go OWN, set grant[w]=1, owner=w, bus_busy=1, rr pointer=(w+1) mod N_REQ,
//     hold counter=1. If req[w]=0 (abandoned) go IDLE, no grant, pointer kept.
//   - Latency: req first sampled at edge E -> grant high after edge E+DEAD_CYC.
//   - OWN: grant held while req[w]=1. Non-owner requests ignored (no preempt).
//     req[w] sampled 0 -> grant=0, bus_busy=0 at that edge, go IDLE.
//   - Timeout (MAX_HOLD>0): hold counter increments each OWN cycle; at edge
//     where counter==MAX_HOLD and req[w]=1: grant=0, timeout_pulse=1 for one
//     cycle, go IDLE. Owner may re-win only if no other req set (rr order).
//   - Gap: after any release, no driver for >= DEAD_CYC+1 cycles.
//   - owner holds last owner value while bus_busy=0 (don't care to consumer).
//   - Invariant: grant is one-hot or zero every cycle; grant!=0 iff bus_busy.
//   - Counter widths: dead counter clog2(DEAD_CYC+1), hold counter
//     clog2(MAX_HOLD+1); no wrap permitted (saturate if MAX_HOLD=0).
//
// TESTING
//   1 N_REQ=2,DEAD=1: req=01 sampled edge 0 -> grant=01 after edge 1, owner=0,
//     bus_busy=1; req=00 -> grant=00, bus_busy=0 after next edge.
//   2 req=11 from reset -> grant=01; drop req[0] keeping req[1] -> grant=00 for
//     2 cycles, then grant=10, owner=1; raise req[0] -> no preemption.
//   3 MAX_HOLD=4, req=11 held -> grant=01 for 4 cycles, timeout_pulse=1 one
//     cycle, gap 2 cycles, grant=10 for 4 cycles, then 01 again.
//   4 req=01 for one cycle only -> DEAD completes, grant never rises, back to
//     IDLE; following req=11 still grants 01 (pointer unchanged).
//   5 rst_n=0 asynchronously mid-grant (between edges) -> grant=0, bus_busy=0,
//     owner=0 before next CLK; release with req=10 -> grant=10 after DEAD_CYC+1.
//   6 Random req, N_REQ=4, DEAD=2, 10k cycles: assert onehot0(grant), gap>=3
//     between different owners, every held request granted within 4 rounds.

Source files
------------

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//   Round-robin arbiter feeding the tristate enables of a shared data bus.
//   At most one grant bit is ever high. Every new grant is preceded by a
//   break-before-make dead time in which no driver is enabled. An owner keeps
//   the bus while it requests, and optionally only up to MAX_HOLD cycles.
//
// Ports
//   CLK           in   system clock, rising edge
//   rst_n         in   asynchronous active-low reset
//   req           in   level request per requester
//   grant         out  registered one-hot-or-zero tristate enables
//   owner         out  index of current (or last) owner
//   bus_busy      out  high while any grant bit is high
//   timeout_pulse out  one-cycle pulse when the hold limit forces a release
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
   parameter int N_REQ    = 2,
   parameter int DEAD_CYC = 1,
   parameter int MAX_HOLD = 16,
   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic             CLK,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] grant,
   output logic [OW-1:0]    owner,
   output logic             bus_busy,
   output logic             timeout_pulse
);
   localparam int DW = $clog2(DEAD_CYC + 1);
   // MAX_HOLD=0 still needs a 1-bit counter; it simply saturates.
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DEAD = 2'd1;
   localparam logic [1:0] S_OWN  = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [OW-1:0]      w_q, w_d, ptr_q, ptr_d, owner_q, owner_d;
   logic [OW-1:0]      win, ptr_nxt;
   logic [DW-1:0]      dcnt_q, dcnt_d;
   logic [HW-1:0]      hcnt_q, hcnt_d;
   logic [N_REQ-1:0]   grant_q, grant_d, rot, w_oh;
   logic [2*N_REQ-1:0] req2;
   logic               busy_q, busy_d, tpulse_q, tpulse_d, req_w;

   // Rotate requests so bit 0 is the rr pointer position; the lowest set bit
   // of the rotated vector is the next winner.
   assign req2 = {req, req} >> ptr_q;
   assign rot  = req2[N_REQ-1:0];

   always_comb begin
      win = ptr_q;
      // Descending scan: the last assignment is the lowest set rotated bit.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            if (int'(ptr_q) + i >= N_REQ) win = OW'(int'(ptr_q) + i - N_REQ);
            else                          win = OW'(int'(ptr_q) + i);
         end
      end
   end

   assign w_oh    = {{(N_REQ-1){1'b0}}, 1'b1} << w_q;
   assign req_w   = |(req & w_oh);
   assign ptr_nxt = (w_q == OW'(N_REQ - 1)) ? '0 : w_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      w_d      = w_q;
      ptr_d    = ptr_q;
      dcnt_d   = dcnt_q;
      hcnt_d   = hcnt_q;
      grant_d  = grant_q;
      owner_d  = owner_q;
      busy_d   = busy_q;
      tpulse_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               w_d     = win;
               dcnt_d  = DW'(DEAD_CYC - 1);
               state_d = S_DEAD;
            end
         end
         S_DEAD: begin
            if (dcnt_q != '0) begin
               dcnt_d = dcnt_q - 1'b1;
            end else if (req_w) begin
               state_d = S_OWN;
               grant_d = w_oh;
               owner_d = w_q;
               busy_d  = 1'b1;
               ptr_d   = ptr_nxt;
               hcnt_d  = HW'(1);
            end else begin
               // Candidate gave up during dead time: no grant, pointer kept.
               state_d = S_IDLE;
            end
         end
         S_OWN: begin
            if (!req_w || (MAX_HOLD > 0 && hcnt_q == HW'(MAX_HOLD))) begin
               state_d  = S_IDLE;
               grant_d  = '0;
               busy_d   = 1'b0;
               hcnt_d   = '0;
               tpulse_d = req_w;
            end else if (hcnt_q != '1) begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         w_q      <= '0;
         ptr_q    <= '0;
         dcnt_q   <= '0;
         hcnt_q   <= '0;
         grant_q  <= '0;
         owner_q  <= '0;
         busy_q   <= 1'b0;
         tpulse_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         w_q      <= w_d;
         ptr_q    <= ptr_d;
         dcnt_q   <= dcnt_d;
         hcnt_q   <= hcnt_d;
         grant_q  <= grant_d;
         owner_q  <= owner_d;
         busy_q   <= busy_d;
         tpulse_q <= tpulse_d;
      end
   end

   assign grant         = grant_q;
   assign owner         = owner_q;
   assign bus_busy      = busy_q;
   assign timeout_pulse = tpulse_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter_rr
//   Two arbiters: A (2 requesters, dead 1, hold limit 4) runs the directed
//   scenarios plus a short random phase; B (4 requesters, dead 2, hold 16)
//   runs a long random phase with bus-safety and fairness checks.
//   Drivers push the reference model's expected outputs into per-DUT queues;
//   monitors pop and compare after each rising edge.
// -----------------------------------------------------------------------------
module tb_bus_arbiter_rr;
   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       rst_a_n = 1'b1, rst_b_n = 1'b1;
   logic [1:0] req_a, grant_a;
   logic       owner_a, busy_a, tp_a;
   logic [3:0] req_b, grant_b;
   logic [1:0] owner_b;
   logic       busy_b, tp_b;

   bus_arbiter_rr #(.N_REQ(2), .DEAD_CYC(1), .MAX_HOLD(4)) u_a (
      .CLK(CLK), .rst_n(rst_a_n), .req(req_a), .grant(grant_a),
      .owner(owner_a), .bus_busy(busy_a), .timeout_pulse(tp_a));

   bus_arbiter_rr #(.N_REQ(4), .DEAD_CYC(2), .MAX_HOLD(16)) u_b (
      .CLK(CLK), .rst_n(rst_b_n), .req(req_b), .grant(grant_b),
      .owner(owner_b), .bus_busy(busy_b), .timeout_pulse(tp_b));

   // phase: 0 nobody, 1 waiting out dead time for 'who', 2 'who' owns the bus
   typedef struct { int phase; int who; int ptr; int left; int held; int last; } ms_t;
   typedef struct { logic [7:0] grant; int owner; logic busy; logic tp; } exp_t;

   int   vectors = 0, miscompares = 0;
   exp_t q_a[$], q_b[$];
   ms_t  m_a, m_b;
   int   wait_b[4] = '{0, 0, 0, 0};
   int   idle_b = 100;
   logic [3:0] pg_b = 4'd0;

   function automatic void m_reset(output ms_t s);
      s.phase = 0; s.who = 0; s.ptr = 0; s.left = 0; s.held = 0; s.last = 0;
   endfunction

   // One clock edge of the arbiter, given the request level seen at that edge.
   task automatic m_step(inout ms_t s, input logic [7:0] r, input int n,
                         input int dead, input int maxh, output exp_t e);
      e.tp = 1'b0;
      case (s.phase)
         0: begin
            for (int k = 0; k < n; k++) begin
               int idx;
               idx = (s.ptr + k) % n;
               if (s.phase == 0 && r[idx]) begin
                  s.who = idx; s.left = dead - 1; s.phase = 1;
               end
            end
         end
         1: begin
            if (s.left > 0) s.left--;
            else if (r[s.who]) begin
               s.phase = 2; s.last = s.who; s.ptr = (s.who + 1) % n; s.held = 1;
            end else s.phase = 0;
         end
         default: begin
            if (!r[s.who]) s.phase = 0;
            else if (maxh > 0 && s.held == maxh) begin s.phase = 0; e.tp = 1'b1; end
            else s.held++;
         end
      endcase
      e.grant = (s.phase == 2) ? 8'(1 << s.who) : 8'd0;
      e.owner = s.last;
      e.busy  = (s.phase == 2);
   endtask

   task automatic drive_a(input logic [1:0] r, input int cycles);
      exp_t e;
      repeat (cycles) begin
         @(negedge CLK);
         req_a = r;
         m_step(m_a, {6'd0, r}, 2, 1, 4, e);
         q_a.push_back(e);
      end
   endtask

   task automatic chk_rst(input string nm, input logic [3:0] g, input int o,
                          input logic b, input logic t);
      vectors++;
      if (g !== 4'd0 || o != 0 || b !== 1'b0 || t !== 1'b0) begin
         miscompares++;
         $display("FAIL %s: grant=%b owner=%0d busy=%b tp=%b, want all zero", nm, g, o, b, t);
      end
   endtask

   // Asserted between edges so the drop must be asynchronous.
   task automatic reset_a();
      @(posedge CLK); #3;
      req_a = 2'b00; rst_a_n = 1'b0;
      #1 chk_rst("a_async_rst", {2'b00, grant_a}, int'(owner_a), busy_a, tp_a);
      m_reset(m_a);
      @(negedge CLK); rst_a_n = 1'b1;
   endtask

   task automatic seq_a();
      logic [1:0] r;
      // single request, grant then release
      drive_a(2'b01, 3); drive_a(2'b00, 3);
      // both from reset, handover without preemption
      reset_a();
      drive_a(2'b11, 3); drive_a(2'b10, 5); drive_a(2'b11, 3); drive_a(2'b00, 3);
      // hold limit with both held
      reset_a();
      drive_a(2'b11, 20); drive_a(2'b00, 3);
      // abandoned during dead time, pointer unchanged
      reset_a();
      drive_a(2'b01, 1); drive_a(2'b00, 3); drive_a(2'b11, 4); drive_a(2'b00, 3);
      // reset mid-grant, then fresh request from requester 1
      reset_a();
      drive_a(2'b01, 4);
      reset_a();
      drive_a(2'b10, 4); drive_a(2'b00, 2);
      // random
      r = 2'b00;
      repeat (400) begin
         for (int i = 0; i < 2; i++) if ($urandom_range(0, 3) == 0) r[i] = ~r[i];
         drive_a(r, 1);
      end
      drive_a(2'b00, 2);
   endtask

   task automatic seq_b();
      logic [3:0] r;
      exp_t e;
      r = 4'd0;
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < 4; i++) if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
         @(negedge CLK);
         req_b = r;
         m_step(m_b, {4'd0, r}, 4, 2, 16, e);
         q_b.push_back(e);
      end
   endtask

   initial begin : mon_a
      exp_t ea;
      forever begin
         @(posedge CLK); #1;
         if (q_a.size() > 0) begin
            ea = q_a.pop_front();
            vectors++;
            if (grant_a !== ea.grant[1:0] || owner_a !== 1'(ea.owner) ||
                busy_a !== ea.busy || tp_a !== ea.tp) begin
               miscompares++;
               $display("FAIL a_out @%0t: grant=%b owner=%b busy=%b tp=%b, want grant=%b owner=%0d busy=%b tp=%b",
                        $time, grant_a, owner_a, busy_a, tp_a, ea.grant[1:0], ea.owner, ea.busy, ea.tp);
            end
         end
      end
   end

   initial begin : mon_b
      exp_t eb;
      forever begin
         @(posedge CLK); #1;
         if (q_b.size() > 0) begin
            eb = q_b.pop_front();
            vectors++;
            if (grant_b !== eb.grant[3:0] || owner_b !== 2'(eb.owner) ||
                busy_b !== eb.busy || tp_b !== eb.tp) begin
               miscompares++;
               $display("FAIL b_out @%0t: grant=%b owner=%0d busy=%b tp=%b, want grant=%b owner=%0d busy=%b tp=%b",
                        $time, grant_b, owner_b, busy_b, tp_b, eb.grant[3:0], eb.owner, eb.busy, eb.tp);
            end
         end
         if (rst_b_n) begin
            vectors++;
            if (!$onehot0(grant_b) || busy_b !== (grant_b != 4'd0)) begin
               miscompares++;
               $display("FAIL b_onehot @%0t: grant=%b busy=%b, want onehot0 and busy==|grant",
                        $time, grant_b, busy_b);
            end
            if (grant_b != 4'd0 && pg_b == 4'd0) begin
               vectors++;
               if (idle_b < 3) begin
                  miscompares++;
                  $display("FAIL b_gap @%0t: idle gap %0d cycles, want >= 3", $time, idle_b);
               end
            end
            idle_b = (grant_b == 4'd0) ? idle_b + 1 : 0;
            pg_b   = grant_b;
            vectors++;
            for (int i = 0; i < 4; i++) begin
               wait_b[i] = (req_b[i] && !grant_b[i]) ? wait_b[i] + 1 : 0;
               if (wait_b[i] == 320) begin
                  miscompares++;
                  $display("FAIL b_starve @%0t: req%0d waited %0d cycles, want < 320", $time, i, wait_b[i]);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: run did not finish, got timeout, want completion");
      $fatal(1);
   end

   initial begin : main
      req_a = 2'b00; req_b = 4'd0;
      #1 rst_a_n = 1'b0; rst_b_n = 1'b0;
      #1;
      chk_rst("a_reset", {2'b00, grant_a}, int'(owner_a), busy_a, tp_a);
      chk_rst("b_reset", grant_b, int'(owner_b), busy_b, tp_b);
      m_reset(m_a); m_reset(m_b);
      @(negedge CLK); @(negedge CLK);
      rst_a_n = 1'b1; rst_b_n = 1'b1;
      fork
         seq_a();
         seq_b();
      join
      repeat (2) @(posedge CLK);
      #2;
      vectors++;
      if (q_a.size() != 0 || q_b.size() != 0) begin
         miscompares++;
         $display("FAIL drain: queued a=%0d b=%0d, want 0", q_a.size(), q_b.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
